// File: rtl/stage1_flit_arbiter.sv
// stage1_flit_arbiter: merges system, heartbeat-request and data-packet flit
// sources onto the single stage-1 input. System beats heartbeat, which beats
// data. A data packet holds the output from head to tail. An offered but
// refused flit is frozen in place until stage 1 takes it.
// Optional build macro: STAGE1_ARB_STARVATION_GUARD_EN adds an aging counter
// that promotes a long-refused data head above system and heartbeat traffic.

package types;
    typedef logic [31:0] flit_t;
endpackage

module stage1_flit_arbiter #(
    parameter int STARVE_LIMIT = 16
) (
    input  logic         nocclk,
    input  logic         rst,
    input  logic         in_sys_valid,
    input  types::flit_t in_sys_flit,
    output logic         out_sys_ready,
    input  logic         in_hb_valid,
    input  types::flit_t in_hb_flit,
    output logic         out_hb_ready,
    input  logic         in_data_valid,
    input  types::flit_t in_data_flit,
    input  logic         in_data_is_head,
    input  logic         in_data_is_tail,
    output logic         out_flit_valid,
    output types::flit_t out_flit,
    input  logic         in_flit_ready,
    output logic [2:0]   out_grant,
    output logic         out_locked,
    output logic         out_promote
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be >= 1");
    end

    // Grant bit positions: [0]=sys, [1]=hb, [2]=data
    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_SYS  = 3'b001;
    localparam logic [2:0] G_HB   = 3'b010;
    localparam logic [2:0] G_DATA = 3'b100;

    typedef enum logic [1:0] {ARB, HOLD, LOCK} state_t;

    state_t     state;
    logic [2:0] grant_q;
    logic       locked;
    logic [2:0] grant;
    logic       fire;
    logic       data_fire;
    logic       data_head;
    logic       promo_sel;

    assign data_head = in_data_valid && in_data_is_head;

`ifdef STAGE1_ARB_STARVATION_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] wait_cnt;
    logic          promo_held;

    // A starved head jumps the queue on a fresh arbitration decision only
    assign promo_sel = (state == ARB) && data_head && (wait_cnt >= CW'(STARVE_LIMIT));
`else
    assign promo_sel = 1'b0;
`endif

    // Grant selection: fresh priority pick in ARB, frozen in HOLD, data-only in LOCK
    always_comb begin
        grant = G_NONE;
        if (!rst) begin
            case (state)
                ARB: begin
                    if (promo_sel)         grant = G_DATA;
                    else if (in_sys_valid) grant = G_SYS;
                    else if (in_hb_valid)  grant = G_HB;
                    else if (data_head)    grant = G_DATA;
                end
                HOLD:    grant = grant_q;
                LOCK:    if (in_data_valid) grant = G_DATA;
                default: grant = G_NONE;
            endcase
        end
    end

    // Zero-latency output mux driven by the one-hot grant
    always_comb begin
        out_flit = '0;
        if (grant[0])      out_flit = in_sys_flit;
        else if (grant[1]) out_flit = in_hb_flit;
        else if (grant[2]) out_flit = in_data_flit;
    end

    assign out_flit_valid = (grant[0] && in_sys_valid) ||
                            (grant[1] && in_hb_valid)  ||
                            (grant[2] && in_data_valid);
    assign fire           = out_flit_valid && in_flit_ready;
    assign data_fire      = fire && grant[2];
    assign out_sys_ready  = in_flit_ready && grant[0];
    assign out_hb_ready   = in_flit_ready && grant[1];
    assign out_grant      = grant;
    assign out_locked     = locked;

    // Arbitration FSM: freeze refused grants, lock the output across a packet
    always_ff @(posedge nocclk) begin
        if (rst) begin
            state   <= ARB;
            grant_q <= G_NONE;
            locked  <= 1'b0;
        end else begin
            case (state)
                ARB, HOLD: begin
                    if (fire) begin
                        grant_q <= G_NONE;
                        if (grant[2] && in_data_is_head && !in_data_is_tail) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                        end else begin
                            state <= ARB;
                        end
                    end else if (grant != G_NONE) begin
                        state   <= HOLD;
                        grant_q <= grant;
                    end
                end
                LOCK: begin
                    if (data_fire && in_data_is_tail) begin
                        state  <= ARB;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state   <= ARB;
                    grant_q <= G_NONE;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STAGE1_ARB_STARVATION_GUARD_EN
    // Age a refused data head; remember whether a frozen data grant was a promotion
    always_ff @(posedge nocclk) begin
        if (rst) begin
            wait_cnt   <= '0;
            promo_held <= 1'b0;
        end else begin
            if (data_fire && in_data_is_head)
                wait_cnt <= '0;
            else if (state != LOCK && data_head && !grant[2] &&
                     wait_cnt < CW'(STARVE_LIMIT))
                wait_cnt <= wait_cnt + 1'b1;

            if (state == ARB)
                promo_held <= promo_sel && !fire;
            else if (fire)
                promo_held <= 1'b0;
        end
    end

    assign out_promote = data_fire && (promo_sel || (state == HOLD && promo_held));
`else
    assign out_promote = 1'b0;
`endif

endmodule

// File: tb/tb_stage1_flit_arbiter.sv
// Bench for stage1_flit_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a source-level reference model.
module tb_stage1_flit_arbiter;
    import types::*;

    localparam int LIMIT = 4;
`ifdef STAGE1_ARB_STARVATION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       nocclk = 1'b0;
    logic       rst;
    logic       in_sys_valid, in_hb_valid, in_data_valid;
    flit_t      in_sys_flit, in_hb_flit, in_data_flit;
    logic       in_data_is_head, in_data_is_tail, in_flit_ready;
    logic       out_sys_ready, out_hb_ready, out_flit_valid;
    flit_t      out_flit;
    logic [2:0] out_grant;
    logic       out_locked, out_promote;

    stage1_flit_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .nocclk          (nocclk),
        .rst             (rst),
        .in_sys_valid    (in_sys_valid),
        .in_sys_flit     (in_sys_flit),
        .out_sys_ready   (out_sys_ready),
        .in_hb_valid     (in_hb_valid),
        .in_hb_flit      (in_hb_flit),
        .out_hb_ready    (out_hb_ready),
        .in_data_valid   (in_data_valid),
        .in_data_flit    (in_data_flit),
        .in_data_is_head (in_data_is_head),
        .in_data_is_tail (in_data_is_tail),
        .out_flit_valid  (out_flit_valid),
        .out_flit        (out_flit),
        .in_flit_ready   (in_flit_ready),
        .out_grant       (out_grant),
        .out_locked      (out_locked),
        .out_promote     (out_promote)
    );

    always #5 nocclk = ~nocclk;

    int total = 0;
    int fails = 0;
    bit regs_ok = 1'b0;

    // Source state: a pending flit stays offered until accepted
    logic  s_v, h_v, d_v, d_h, d_t, rdy, r;
    flit_t s_f, h_f, d_f;
    int    d_idx, d_len;

    // Reference model: packet in flight, frozen owner (-1 none), aging count
    bit m_lock;
    int m_hold;
    bit m_hpromo;
    int m_wait;

    // DUT outputs captured at the last check point, for directed assertions
    logic [2:0] obs_grant;
    logic       obs_locked, obs_promote, obs_sys_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int g;
        bit promo, ev, acc, pr;
        logic [31:0] ef;
        rst = r; in_flit_ready = rdy;
        in_sys_valid = s_v; in_sys_flit = s_f;
        in_hb_valid = h_v; in_hb_flit = h_f;
        in_data_valid = d_v; in_data_flit = d_f;
        in_data_is_head = d_h; in_data_is_tail = d_t;
        #2;
        promo = 1'b0;
        g = -1;
        if (r) g = -1;
        else if (m_lock) g = d_v ? 2 : -1;
        else if (m_hold >= 0) g = m_hold;
        else begin
            promo = GUARD && (m_wait >= LIMIT) && d_v && d_h;
            if (promo) g = 2;
            else if (s_v) g = 0;
            else if (h_v) g = 1;
            else if (d_v && d_h) g = 2;
        end
        ev  = (g == 0 && s_v) || (g == 1 && h_v) || (g == 2 && d_v);
        ef  = (g == 0) ? s_f : (g == 1) ? h_f : (g == 2) ? d_f : 32'h0;
        acc = ev && rdy;
        pr  = GUARD && acc && (g == 2) && (promo || (m_hold == 2 && m_hpromo));
        chk("grant", {29'd0, out_grant}, (g < 0) ? 32'd0 : (32'd1 << g));
        chk("flit_valid", {31'd0, out_flit_valid}, {31'd0, ev});
        chk("flit", out_flit, ef);
        chk("sys_ready", {31'd0, out_sys_ready}, {31'd0, rdy && g == 0});
        chk("hb_ready", {31'd0, out_hb_ready}, {31'd0, rdy && g == 1});
        chk("promote", {31'd0, out_promote}, {31'd0, pr});
        if (regs_ok) chk("locked", {31'd0, out_locked}, {31'd0, m_lock});
        obs_grant = out_grant; obs_locked = out_locked;
        obs_promote = out_promote; obs_sys_rdy = out_sys_ready;
        @(posedge nocclk);
        #1;
        regs_ok = 1'b1;
        if (r) begin
            m_lock = 0; m_hold = -1; m_hpromo = 0; m_wait = 0;
            s_v = 0; h_v = 0; d_v = 0; d_idx = 0;
        end else begin
            if (!m_lock) begin
                if (acc && g == 2 && d_h) m_wait = 0;
                else if (d_v && d_h && g != 2 && m_wait < LIMIT) m_wait++;
            end
            if (m_lock) begin
                if (acc && d_t) m_lock = 0;
            end else if (acc) begin
                m_hold = -1; m_hpromo = 0;
                if (g == 2 && !d_t) m_lock = 1;
            end else if (g >= 0) begin
                if (m_hold < 0) m_hpromo = promo;
                m_hold = g;
            end
            if (acc) begin
                case (g)
                    0: s_v = 0;
                    1: h_v = 0;
                    default: begin d_v = 0; d_idx = d_t ? 0 : d_idx + 1; end
                endcase
            end
        end
    endtask

    task automatic rand_src();
        if (!s_v && $urandom_range(0, 2) == 0) begin s_v = 1; s_f = $urandom; end
        if (!h_v && $urandom_range(0, 3) == 0) begin h_v = 1; h_f = $urandom; end
        if (!d_v && $urandom_range(0, 1) == 0) begin
            if (d_idx == 0) d_len = $urandom_range(1, 4);
            d_v = 1; d_f = $urandom;
            d_h = (d_idx == 0); d_t = (d_idx == d_len - 1);
        end
        rdy = ($urandom_range(0, 3) != 0);
        r   = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        s_v = 0; h_v = 0; d_v = 0; d_h = 0; d_t = 0;
        s_f = '0; h_f = '0; d_f = '0; d_idx = 0; d_len = 1;
        m_lock = 0; m_hold = -1; m_hpromo = 0; m_wait = 0;
        r = 1; rdy = 1;
        #1;
        cycle(); cycle();
        chk("rst_grant", {29'd0, obs_grant}, 32'd0);
        r = 0;

        // Priority: sys, then hb, then data head
        s_v = 1; s_f = 32'h5151_0001; h_v = 1; h_f = 32'h4848_0002;
        d_v = 1; d_f = 32'hDADA_0003; d_h = 1; d_t = 1; rdy = 1;
        cycle(); chk("prio_1st", {29'd0, obs_grant}, 32'b001);
        cycle(); chk("prio_2nd", {29'd0, obs_grant}, 32'b010);
        cycle(); chk("prio_3rd", {29'd0, obs_grant}, 32'b100);

        // Hold: refused hb is not preempted by a later sys
        h_v = 1; h_f = 32'h4848_00AA; rdy = 0;
        cycle(); cycle(); cycle();
        s_v = 1; s_f = 32'h5151_00BB;
        cycle(); chk("hold_frozen", {29'd0, obs_grant}, 32'b010);
        rdy = 1;
        cycle(); chk("hold_release", {29'd0, obs_grant}, 32'b010);
        cycle(); chk("hold_then_sys", {29'd0, obs_grant}, 32'b001);

        // Lock: 4-flit packet with a bubble after body1, sys waiting
        d_v = 1; d_h = 1; d_t = 0; d_f = 32'hDADA_0010;
        cycle(); chk("lock_head", {29'd0, obs_grant}, 32'b100);
        s_v = 1; s_f = 32'h5151_00CC;
        d_v = 1; d_h = 0; d_t = 0; d_f = 32'hDADA_0011;
        cycle(); chk("lock_body1_sysrdy", {31'd0, obs_sys_rdy}, 32'd0);
        chk("lock_body1_locked", {31'd0, obs_locked}, 32'd1);
        cycle(); chk("lock_bubble_grant", {29'd0, obs_grant}, 32'd0);
        d_v = 1; d_f = 32'hDADA_0012;
        cycle(); chk("lock_body2_grant", {29'd0, obs_grant}, 32'b100);
        d_v = 1; d_t = 1; d_f = 32'hDADA_0013;
        cycle(); chk("lock_tail_locked", {31'd0, obs_locked}, 32'd1);
        cycle(); chk("after_tail_sys", {29'd0, obs_grant}, 32'b001);
        chk("after_tail_unlocked", {31'd0, obs_locked}, 32'd0);

        // Single-flit packet never locks
        d_v = 1; d_h = 1; d_t = 1; d_f = 32'hDADA_0020;
        cycle(); chk("single_grant", {29'd0, obs_grant}, 32'b100);
        cycle(); chk("single_nolock", {31'd0, obs_locked}, 32'd0);

        // Starvation: continuous sys with a waiting data head
        r = 1; cycle(); r = 0;
        d_v = 1; d_h = 1; d_t = 1; d_f = 32'hDADA_0030;
        for (int i = 0; i < 4; i++) begin
            s_v = 1; s_f = $urandom;
            cycle(); chk("starve_sys", {29'd0, obs_grant}, 32'b001);
        end
        s_v = 1; s_f = $urandom;
        cycle();
        chk("starve_5th_grant", {29'd0, obs_grant}, GUARD ? 32'b100 : 32'b001);
        chk("starve_5th_promote", {31'd0, obs_promote}, {31'd0, GUARD});
        for (int i = 0; i < 3; i++) begin
            s_v = 1; s_f = $urandom;
            cycle(); chk("starve_tail_sys", {29'd0, obs_grant}, 32'b001);
        end

        // Reset mid-packet, pending sys goes first afterwards
        r = 1; cycle(); r = 0;
        d_v = 1; d_h = 1; d_t = 0; d_f = 32'hDADA_0040;
        cycle();
        d_v = 1; d_h = 0; d_f = 32'hDADA_0041;
        cycle();
        r = 1; s_v = 1; s_f = 32'h5151_00DD; d_v = 1; d_f = 32'hDADA_0042;
        cycle(); chk("rst_mid_grant", {29'd0, obs_grant}, 32'd0);
        r = 0; s_v = 1; s_f = 32'h5151_00EE;
        cycle(); chk("rst_after_sys", {29'd0, obs_grant}, 32'b001);
        chk("rst_after_unlocked", {31'd0, obs_locked}, 32'd0);

        // Randomized traffic against the model
        s_v = 0; h_v = 0; d_v = 0; d_idx = 0;
        for (int i = 0; i < 3000; i++) begin
            rand_src();
            cycle();
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/stage1_flit_arbiter.md
# stage1_flit_arbiter

Arbitrates three flit sources onto the single router stage-1 input: decoded system flits, heartbeat-request flits, and data packets from the input buffer. It sits between the input-side flit sources and stage 1. System flits win over heartbeat requests, and heartbeat requests win over data. A data packet, once its head is accepted, holds the output until its tail is accepted. An optional aging guard stops data from starving under continuous system or heartbeat traffic.

## Interface
Parameters:
- STARVE_LIMIT, 16, consecutive cycles a pending data head may be refused before it is promoted (guard only); must be ≥1

Ports:
- nocclk  in  1  router clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_sys_valid  in  1  system flit offered
- in_sys_flit  in  types::flit_t  system flit, always single-flit
- out_sys_ready  out  1  system flit accepted this cycle
- in_hb_valid  in  1  heartbeat-request flit offered
- in_hb_flit  in  types::flit_t  heartbeat flit, single-flit
- out_hb_ready  out  1  heartbeat flit accepted this cycle
- in_data_valid  in  1  data flit offered
- in_data_flit  in  types::flit_t  data flit
- in_data_is_head  in  1  offered data flit is a head
- in_data_is_tail  in  1  offered data flit is a tail (head+tail = single-flit packet)
- out_flit_valid  out  1  flit offered to stage 1
- out_flit  out  types::flit_t  offered flit
- in_flit_ready  in  1  stage 1 accepts (stage-1 ready)
- out_grant  out  3  one-hot {data, hb, sys} owner of out_flit; 0 when nothing offered
- out_locked  out  1  mid-packet lock active
- out_promote  out  1  one-cycle pulse when a promoted data head is accepted (guard only)

## Operation
- FSM states: ARB, HOLD, LOCK. Reset enters ARB.
- ARB: the grant is chosen combinationally among the valid sources.
  - Guard promotion active: data head first.
  - Otherwise: sys > hb > data.
  - Data is eligible in ARB only when in_data_is_head=1. A non-head data flit in ARB is a protocol error: it is ignored and never granted.
- Output mux:
  - out_flit_valid = valid of the granted source.
  - out_flit = flit of the granted source.
  - The source's ready = in_flit_ready && its grant bit. All other readies are 0.
- Transitions out of ARB:
  - Offered and not accepted → HOLD. The grant is registered and frozen.
  - Accepted data head with is_tail=0 → LOCK.
  - Any other acceptance → stay in ARB.
- HOLD:
  - The grant is frozen and the flit must remain offered. The source keeps valid high and the flit stable, so higher-priority arrivals do not preempt.
  - On acceptance: a data head with is_tail=0 → LOCK; otherwise → ARB.
- LOCK:
  - Grant = data only. sys and hb readies are 0 regardless of in_flit_ready.
  - Data flits pass whenever in_data_valid; gaps in in_data_valid are allowed.
  - Accepted data flit with is_tail=1 → ARB.
- Simultaneous events:
  - All three valid in ARB → sys is granted (absent promotion).
  - Tail accepted in the same cycle as a sys request → sys is granted the next cycle at the earliest.
- rst asserted mid-packet or in HOLD:
  - Next cycle: state ARB, lock cleared, counter 0.
  - Upstream sources are reset by the same rst.

## Timing
- Data path is zero-latency combinational. A flit offered in cycle N with in_flit_ready=1 is consumed in cycle N.
- State, registered grant, and counter update on the nocclk edge after a handshake.
- Reset values:
  - out_flit_valid=0, out_grant=0, out_locked=0, out_promote=0.
  - All readies 0 during the rst cycle.
  - out_flit=0.
- out_locked is registered. It is 1 from the cycle after head acceptance through the cycle the tail is accepted.
- Per-cycle throughput: at most one flit per cycle.

## Configuration
- Macro STAGE1_ARB_STARVATION_GUARD_EN.
- Defined: a wait counter of width $clog2(STARVE_LIMIT+1) is compiled in.
  - Increments, saturating, each ARB/HOLD cycle in which a valid data head is offered but the grant is not data.
  - Clears on data head acceptance and on rst.
  - When count ≥ STARVE_LIMIT, the next ARB decision grants the data head above sys and hb. out_promote pulses in the cycle that head is accepted.
- Undefined: strict priority sys > hb > data. No counter is present, and out_promote is tied to 0.

## Test plan
- Priority: sys, hb, and data head all valid with ready=1 → grants in consecutive cycles are 001, 010, 100 (readies follow the grant).
- Hold stability: hb granted with ready=0 for 3 cycles, then sys asserts → out_grant stays 010 until ready=1. Sys goes in the following cycle.
- Lock: 4-flit data packet (head, 2 body, tail) with sys valid throughout and one data bubble after body1 → out_sys_ready=0 until the tail is accepted. out_locked=1 for 4 cycles. Sys is granted the cycle after the tail.
- Single-flit data (head+tail) → no lock; out_locked stays 0.
- Guard (macro defined, STARVE_LIMIT=4): sys valid continuously, data head waiting → data granted on the 5th cycle with out_promote=1. Macro undefined → data never granted while sys is valid.
- Reset mid-packet: rst=1 after head+body1 → next cycle state ARB, out_locked=0, counter 0. A pending sys flit is granted first.
